// File: rtl/jogo_sequencia_controle_if.sv
// Control/status bundle between the game controller and the surrounding datapath.
// The master side drives the flags and requests; the controller (slave) returns strobes and results.
interface jogo_sequencia_controle_if;
    logic iniciar;
    logic jogada;
    logic igual;
    logic fimE;
    logic fimL;
    logic zeraE;
    logic zeraL;
    logic zeraR;
    logic contaE;
    logic contaL;
    logic registraR;
    logic pronto;
    logic acertou;
    logic errou;
    logic timeout;
    logic [3:0] db_estado;

    modport master (
        output iniciar, jogada, igual, fimE, fimL,
        input  zeraE, zeraL, zeraR, contaE, contaL, registraR,
               pronto, acertou, errou, timeout, db_estado
    );

    modport slave (
        input  iniciar, jogada, igual, fimE, fimL,
        output zeraE, zeraL, zeraR, contaE, contaL, registraR,
               pronto, acertou, errou, timeout, db_estado
    );
endinterface

// File: rtl/jogo_sequencia_controle.sv
// Moore control unit for the multi-round sequence-memory game, with a per-move timeout timer.
// All outputs decode from the registered state; the timer only runs while waiting for a move.
module jogo_sequencia_controle #(
    parameter int TIMEOUT = 5000
) (
    input  logic                        clock,
    input  logic                        reset,
    jogo_sequencia_controle_if.slave    bus
);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    localparam logic [3:0] INICIAL        = 4'b0000;
    localparam logic [3:0] PREPARACAO     = 4'b0001;
    localparam logic [3:0] INICIO_RODADA  = 4'b0010;
    localparam logic [3:0] ESPERA_JOGADA  = 4'b0011;
    localparam logic [3:0] REGISTRA       = 4'b0100;
    localparam logic [3:0] COMPARACAO     = 4'b0101;
    localparam logic [3:0] PROXIMA_JOGADA = 4'b0110;
    localparam logic [3:0] PROXIMA_RODADA = 4'b0111;
    localparam logic [3:0] FIM_ACERTOU    = 4'b1010;
    localparam logic [3:0] FIM_ERROU      = 4'b1110;
    localparam logic [3:0] FIM_TIMEOUT    = 4'b1101;

    logic [3:0]    state_reg;
    logic [3:0]    state_next;
    logic [TW-1:0] timer_reg;
    logic [TW-1:0] timer_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= INICIAL;
            timer_reg <= '0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            INICIAL:        state_next = bus.iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:     state_next = INICIO_RODADA;
            INICIO_RODADA:  state_next = ESPERA_JOGADA;
            // A move in the last timer cycle still counts: jogada wins over timeout.
            ESPERA_JOGADA: begin
                if (bus.jogada)
                    state_next = REGISTRA;
                else if (timer_reg == TIMER_LAST)
                    state_next = FIM_TIMEOUT;
                else
                    state_next = ESPERA_JOGADA;
            end
            REGISTRA:       state_next = COMPARACAO;
            COMPARACAO: begin
                if (!bus.igual)
                    state_next = FIM_ERROU;
                else if (bus.fimE && bus.fimL)
                    state_next = FIM_ACERTOU;
                else if (bus.fimE)
                    state_next = PROXIMA_RODADA;
                else
                    state_next = PROXIMA_JOGADA;
            end
            PROXIMA_JOGADA: state_next = ESPERA_JOGADA;
            PROXIMA_RODADA: state_next = INICIO_RODADA;
            FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT:
                state_next = bus.iniciar ? PREPARACAO : state_reg;
            default:        state_next = INICIAL;
        endcase
    end

    // Counting only while staying in the wait state makes every entry start from zero
    // and keeps the counter from ever reaching TIMEOUT.
    assign timer_next = (state_reg == ESPERA_JOGADA && state_next == ESPERA_JOGADA)
                        ? timer_reg + 1'b1 : '0;

    always_comb begin
        bus.zeraE     = 1'b0;
        bus.zeraL     = 1'b0;
        bus.zeraR     = 1'b0;
        bus.contaE    = 1'b0;
        bus.contaL    = 1'b0;
        bus.registraR = 1'b0;
        bus.pronto    = 1'b0;
        bus.acertou   = 1'b0;
        bus.errou     = 1'b0;
        bus.timeout   = 1'b0;
        bus.db_estado = state_reg;
        case (state_reg)
            INICIAL, PREPARACAO: begin
                bus.zeraE = 1'b1;
                bus.zeraL = 1'b1;
                bus.zeraR = 1'b1;
            end
            INICIO_RODADA:  bus.zeraE = 1'b1;
            ESPERA_JOGADA:  ;
            REGISTRA:       bus.registraR = 1'b1;
            COMPARACAO:     ;
            PROXIMA_JOGADA: bus.contaE = 1'b1;
            PROXIMA_RODADA: bus.contaL = 1'b1;
            FIM_ACERTOU: begin
                bus.pronto  = 1'b1;
                bus.acertou = 1'b1;
            end
            FIM_ERROU: begin
                bus.pronto = 1'b1;
                bus.errou  = 1'b1;
            end
            FIM_TIMEOUT: begin
                bus.pronto  = 1'b1;
                bus.errou   = 1'b1;
                bus.timeout = 1'b1;
            end
            default:        bus.db_estado = 4'b1111;
        endcase
    end
endmodule

// File: tb/tb_jogo_sequencia_controle.sv
// Directed bench for jogo_sequencia_controle with TIMEOUT = 8; checks state code, strobes and timer.
module tb_jogo_sequencia_controle;
    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;

    jogo_sequencia_controle_if bus ();

    jogo_sequencia_controle #(.TIMEOUT(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected strobes per state: {zeraE,zeraL,zeraR,contaE,contaL,registraR,pronto,acertou,errou,timeout}
    function automatic logic [9:0] exp_out(input logic [3:0] code);
        case (code)
            4'h0, 4'h1: return 10'b111_0000000;
            4'h2:       return 10'b100_0000000;
            4'h4:       return 10'b000_0010000;
            4'h6:       return 10'b000_1000000;
            4'h7:       return 10'b000_0100000;
            4'hA:       return 10'b000_0001100;
            4'hE:       return 10'b000_0001010;
            4'hD:       return 10'b000_0001011;
            default:    return 10'b000_0000000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_state(input string tag, input logic [3:0] code);
        logic [9:0] outs;
        outs = {bus.zeraE, bus.zeraL, bus.zeraR, bus.contaE, bus.contaL, bus.registraR,
                bus.pronto, bus.acertou, bus.errou, bus.timeout};
        chk({tag, "_estado"}, 32'(bus.db_estado), 32'(code));
        chk({tag, "_saidas"}, 32'(outs), 32'(exp_out(code)));
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        bus.iniciar = 1'b0;
        bus.jogada  = 1'b0;
        bus.igual   = 1'b0;
        bus.fimE    = 1'b0;
        bus.fimL    = 1'b0;
        #2;
        chk_state("reset", 4'h0);
        chk("reset_timer", 32'(dut.timer_reg), 0);
        step();
        reset = 1'b0;
        step(); chk_state("idle", 4'h0);

        // single-round win
        bus.iniciar = 1'b1;
        step(); chk_state("w1_prep", 4'h1);
        bus.iniciar = 1'b0;
        step(); chk_state("w1_rodada", 4'h2);
        step(); chk_state("w1_espera", 4'h3);
        bus.jogada = 1'b1; bus.igual = 1'b1; bus.fimE = 1'b1; bus.fimL = 1'b1;
        step(); chk_state("w1_registra", 4'h4);
        bus.jogada = 1'b0;
        step(); chk_state("w1_compara", 4'h5);
        step(); chk_state("w1_acertou", 4'hA);
        step(); chk_state("w1_hold", 4'hA);
        step(); chk_state("w1_hold2", 4'hA);

        // wrong move on the second item
        bus.iniciar = 1'b1;
        step(); chk_state("e_prep", 4'h1);
        bus.iniciar = 1'b0;
        step(); chk_state("e_rodada", 4'h2);
        step(); chk_state("e_espera", 4'h3);
        bus.jogada = 1'b1; bus.igual = 1'b1; bus.fimE = 1'b0; bus.fimL = 1'b0;
        step(); chk_state("e_registra", 4'h4);
        bus.jogada = 1'b0;
        step(); chk_state("e_compara", 4'h5);
        step(); chk_state("e_proxjog", 4'h6);
        step(); chk_state("e_espera2", 4'h3);
        chk("e_timer0", 32'(dut.timer_reg), 0);
        bus.jogada = 1'b1; bus.igual = 1'b0;
        step(); chk_state("e_registra2", 4'h4);
        bus.jogada = 1'b0;
        step(); chk_state("e_compara2", 4'h5);
        step(); chk_state("e_errou", 4'hE);
        step(); chk_state("e_hold", 4'hE);

        // restart from fim_errou
        bus.iniciar = 1'b1; bus.igual = 1'b1;
        step(); chk_state("restart_prep", 4'h1);
        bus.iniciar = 1'b0;

        // timeout: no move for the whole window
        step(); chk_state("t_rodada", 4'h2);
        step(); chk_state("t_espera", 4'h3);
        chk("t_timer_entry", 32'(dut.timer_reg), 0);
        for (int k = 1; k <= 7; k++) begin
            step();
            chk_state("t_wait", 4'h3);
            chk("t_timer", 32'(dut.timer_reg), 32'(k));
        end
        step(); chk_state("t_timeout", 4'hD);
        chk("t_timer_clear", 32'(dut.timer_reg), 0);
        step(); chk_state("t_hold", 4'hD);

        // move in the last window cycle beats the timeout; then a two-round win
        bus.iniciar = 1'b1;
        step(); chk_state("b_prep", 4'h1);
        bus.iniciar = 1'b0;
        step(); chk_state("b_rodada", 4'h2);
        step(); chk_state("b_espera", 4'h3);
        for (int k = 1; k <= 7; k++) step();
        chk_state("b_last_cycle", 4'h3);
        bus.jogada = 1'b1; bus.igual = 1'b1; bus.fimE = 1'b1; bus.fimL = 1'b0;
        step(); chk_state("b_registra", 4'h4);
        bus.jogada = 1'b0;
        step(); chk_state("r1_compara", 4'h5);
        step(); chk_state("r1_proxrodada", 4'h7);
        step(); chk_state("r2_rodada", 4'h2);
        step(); chk_state("r2_espera", 4'h3);
        bus.jogada = 1'b1; bus.fimE = 1'b0; bus.fimL = 1'b0;
        step(); chk_state("r2_registra", 4'h4);
        bus.jogada = 1'b0;
        step(); chk_state("r2_compara", 4'h5);
        step(); chk_state("r2_proxjog", 4'h6);
        step(); chk_state("r2_espera2", 4'h3);
        chk("r2_timer0", 32'(dut.timer_reg), 0);
        step();
        chk("r2_timer1", 32'(dut.timer_reg), 1);
        bus.jogada = 1'b1; bus.fimE = 1'b1; bus.fimL = 1'b1;
        step(); chk_state("r2_registra2", 4'h4);
        bus.jogada = 1'b0;
        step(); chk_state("r2_compara2", 4'h5);
        step(); chk_state("r2_acertou", 4'hA);

        // asynchronous reset mid-clock while waiting for a move
        bus.iniciar = 1'b1;
        step(); chk_state("x_prep", 4'h1);
        bus.iniciar = 1'b0;
        step(); step(); step(); step();
        chk_state("x_espera", 4'h3);
        chk("x_timer_run", 32'(dut.timer_reg), 2);
        #3 reset = 1'b1;
        #1;
        chk_state("x_async", 4'h0);
        chk("x_timer_async", 32'(dut.timer_reg), 0);
        step();
        reset = 1'b0;
        step(); chk_state("x_idle", 4'h0);
        step(); chk_state("x_idle2", 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
